alu_operand_fetch: RTL and testbench

- Issue stage directly upstream of ALU_Pipeline.
- Accepts RISC-V R-type instructions over a valid/ready handshake and decodes them.
- Reads rs1/rs2 from an internal 32x32 register file and drives A_out/B_out/instr_out into the ALU.
- Tracks rd through the ALU latency, writes Result_in back to rd, and stalls on read-after-write hazards.

---
 rtl/alu_pkg.sv | 69 ++++++
 rtl/alu_operand_fetch_if.sv | 42 ++++
 rtl/alu_regfile.sv | 54 +++++
 rtl/alu_operand_fetch.sv | 159 +++++++++++++++
 tb/tb_alu_operand_fetch.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared decode constants, tracker entry type and R-type decode helpers for
// the ALU operand-fetch stage.
package alu_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_XOR    = 3'b100;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR
    } alu_op_e;

    // One in-flight destination: rides the issue register, then the latency pipe.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
    } trk_entry_t;

    typedef struct packed {
        logic              legal;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } rtype_dec_t;

    function automatic rtype_dec_t rtype_decode(input logic [31:0] instr);
        rtype_dec_t d;
        d.rs1   = instr[19:15];
        d.rs2   = instr[24:20];
        d.rd    = instr[11:7];
        d.legal = 1'b0;
        if (instr[6:0] == OPC_RTYPE) begin
            case (instr[14:12])
                F3_ADDSUB: d.legal = (instr[31:25] == F7_BASE) || (instr[31:25] == F7_SUB);
                F3_AND,
                F3_OR,
                F3_XOR:    d.legal = (instr[31:25] == F7_BASE);
                default:   d.legal = 1'b0;
            endcase
        end
        return d;
    endfunction

    // Operation selected by a legal R-type word; meaningless for illegal words.
    function automatic alu_op_e rtype_op(input logic [31:0] instr);
        alu_op_e op;
        case (instr[14:12])
            F3_AND:  op = OP_AND;
            F3_OR:   op = OP_OR;
            F3_XOR:  op = OP_XOR;
            default: op = (instr[31:25] == F7_SUB) ? OP_SUB : OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_operand_fetch_if.sv
// Instruction-in / operand-out / result-in bus between the operand-fetch
// stage (slave) and its surroundings (master: upstream feeder plus ALU).
interface alu_operand_fetch_if #(
    parameter int XLEN = 32
);
    // Handshake: a word transfers on every rising edge where instr_valid and
    // instr_ready are both high; instr_ready never depends on instr_valid, and
    // the master holds instr_valid/instr_in stable until that transfer.
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr_in;

    logic [XLEN-1:0] A_out;
    logic [XLEN-1:0] B_out;
    logic [31:0]     instr_out;
    logic            issue_valid;

    logic [XLEN-1:0] Result_in;

    modport master (
        output instr_valid,
        output instr_in,
        output Result_in,
        input  instr_ready,
        input  A_out,
        input  B_out,
        input  instr_out,
        input  issue_valid
    );

    modport slave (
        input  instr_valid,
        input  instr_in,
        input  Result_in,
        output instr_ready,
        output A_out,
        output B_out,
        output instr_out,
        output issue_valid
    );

endinterface

// File: rtl/alu_regfile.sv
// 32 x XLEN register file: x0 hardwired to zero, two operand read ports, a
// debug read port and two write ports where writeback beats preload.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [REG_AW-1:0] rd1_addr_i,
    output logic [XLEN-1:0]   rd1_data_o,
    input  logic [REG_AW-1:0] rd2_addr_i,
    output logic [XLEN-1:0]   rd2_data_o,
    input  logic [REG_AW-1:0] dbg_addr_i,
    output logic [XLEN-1:0]   dbg_data_o,

    input  logic              wb_en_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    input  logic [XLEN-1:0]   wb_data_i,

    input  logic              ld_en_i,
    input  logic [REG_AW-1:0] ld_addr_i,
    input  logic [XLEN-1:0]   ld_data_i
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic            wb_we;
    logic            ld_we;

    assign wb_we = wb_en_i && (wb_addr_i != '0);
    // A preload loses to a writeback aimed at the same register.
    assign ld_we = ld_en_i && (ld_addr_i != '0) && !(wb_we && (wb_addr_i == ld_addr_i));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (ld_we) begin
                regs_q[ld_addr_i] <= ld_data_i;
            end
            if (wb_we) begin
                regs_q[wb_addr_i] <= wb_data_i;
            end
        end
    end

    assign rd1_data_o = (rd1_addr_i == '0) ? '0 : regs_q[rd1_addr_i];
    assign rd2_data_o = (rd2_addr_i == '0) ? '0 : regs_q[rd2_addr_i];
    assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_operand_fetch.sv
// Issue stage ahead of the ALU: decodes R-type words, reads operands, tracks rd
// through ALU_LATENCY and writes results back. ALU_OPFETCH_FWD_EN enables
// bypassing Result_in for a match against the writeback entry.
module alu_operand_fetch
    import alu_pkg::*;
#(
    parameter int ALU_LATENCY = 1,
    parameter int XLEN        = 32
) (
    input  logic                clk,
    input  logic                rst,

    alu_operand_fetch_if.slave  bus,

    input  logic                ld_valid,
    input  logic [REG_AW-1:0]   ld_rd,
    input  logic [XLEN-1:0]     ld_data,

    output logic                wb_valid,
    output logic [REG_AW-1:0]   wb_rd,
    output logic [XLEN-1:0]     wb_data,

    output logic                illegal_pulse,

    input  logic [REG_AW-1:0]   dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);

    rtype_dec_t      dec;
    logic            accept;
    logic            hazard;
    logic            stall_hit;
    logic            tail_hit_a;
    logic            tail_hit_b;

    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;
    logic [XLEN-1:0] a_val;
    logic [XLEN-1:0] b_val;

    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [31:0]     instr_q, instr_d;
    logic            issue_valid_q, issue_valid_d;
    logic            illegal_q, illegal_d;

    trk_entry_t      issue_ent_q, issue_ent_d;
    trk_entry_t      pipe_q [ALU_LATENCY];
    trk_entry_t      tail;

    function automatic logic ent_hit(input trk_entry_t e, input logic [REG_AW-1:0] rs);
        return e.valid && (rs != '0) && (e.rd == rs);
    endfunction

    assign dec    = rtype_decode(bus.instr_in);
    assign tail   = pipe_q[ALU_LATENCY-1];
    assign accept = bus.instr_valid && bus.instr_ready;

    // Matches against every in-flight entry except the one retiring this cycle.
    always_comb begin
        stall_hit = ent_hit(issue_ent_q, dec.rs1) || ent_hit(issue_ent_q, dec.rs2);
        for (int i = 0; i < ALU_LATENCY - 1; i++) begin
            stall_hit = stall_hit || ent_hit(pipe_q[i], dec.rs1) || ent_hit(pipe_q[i], dec.rs2);
        end
    end

    assign tail_hit_a = ent_hit(tail, dec.rs1);
    assign tail_hit_b = ent_hit(tail, dec.rs2);

`ifdef ALU_OPFETCH_FWD_EN
    assign hazard = dec.legal && stall_hit;
    assign a_val  = tail_hit_a ? bus.Result_in : rf_rd1;
    assign b_val  = tail_hit_b ? bus.Result_in : rf_rd2;
`else
    // Without bypass the consumer waits until the register file holds the value.
    assign hazard = dec.legal && (stall_hit || tail_hit_a || tail_hit_b);
    assign a_val  = rf_rd1;
    assign b_val  = rf_rd2;
`endif

    assign bus.instr_ready = !rst && !hazard;

    always_comb begin
        a_d           = a_q;
        b_d           = b_q;
        instr_d       = instr_q;
        issue_valid_d = 1'b0;
        illegal_d     = 1'b0;
        issue_ent_d   = '0;
        if (accept) begin
            if (dec.legal) begin
                a_d            = a_val;
                b_d            = b_val;
                instr_d        = bus.instr_in;
                issue_valid_d  = 1'b1;
                issue_ent_d.valid = 1'b1;
                issue_ent_d.rd    = dec.rd;
            end else begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q           <= '0;
            b_q           <= '0;
            instr_q       <= '0;
            issue_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            issue_ent_q   <= '0;
            for (int i = 0; i < ALU_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            a_q           <= a_d;
            b_q           <= b_d;
            instr_q       <= instr_d;
            issue_valid_q <= issue_valid_d;
            illegal_q     <= illegal_d;
            issue_ent_q   <= issue_ent_d;
            pipe_q[0]     <= issue_ent_q;
            for (int i = 1; i < ALU_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign bus.A_out       = a_q;
    assign bus.B_out       = b_q;
    assign bus.instr_out   = instr_q;
    assign bus.issue_valid = issue_valid_q;
    assign illegal_pulse   = illegal_q;

    // The tail entry retires in the same cycle its Result_in arrives.
    assign wb_valid = tail.valid && (tail.rd != '0);
    assign wb_rd    = tail.rd;
    assign wb_data  = bus.Result_in;

    alu_regfile #(
        .XLEN (XLEN)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .rd1_addr_i (dec.rs1),
        .rd1_data_o (rf_rd1),
        .rd2_addr_i (dec.rs2),
        .rd2_data_o (rf_rd2),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .wb_en_i    (wb_valid),
        .wb_addr_i  (wb_rd),
        .wb_data_i  (wb_data),
        .ld_en_i    (ld_valid),
        .ld_addr_i  (ld_rd),
        .ld_data_i  (ld_data)
    );

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Self-checking bench for alu_operand_fetch: scoreboarded issue/writeback
// streams plus per-scenario timing, hazard, decode and reset checks.
module tb_alu_operand_fetch;

    localparam int L    = 1;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            ld_valid;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            illegal_pulse;
    logic [4:0]      dbg_addr;
    logic [XLEN-1:0] dbg_data;

    alu_operand_fetch_if #(.XLEN(XLEN)) bus ();

    alu_operand_fetch #(
        .ALU_LATENCY (L),
        .XLEN        (XLEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .ld_valid      (ld_valid),
        .ld_rd         (ld_rd),
        .ld_data       (ld_data),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .illegal_pulse (illegal_pulse),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_reg [32];
    logic [31:0] exp_a_q[$];
    logic [31:0] exp_b_q[$];
    logic [31:0] exp_i_q[$];
    logic [31:0] exp_r_q[$];
    logic [36:0] exp_wb_q[$];
    logic [31:0] res_sr [L];

`ifdef ALU_OPFETCH_FWD_EN
    localparam int DEP_STALL = L;
`else
    localparam int DEP_STALL = L + 1;
`endif

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic legal_of(input logic [31:0] ins);
        if (ins[6:0] != 7'b0110011) return 1'b0;
        case ({ins[31:25], ins[14:12]})
            10'b0000000_000, 10'b0100000_000, 10'b0000000_111,
            10'b0000000_110, 10'b0000000_100: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] alu_of(input logic [31:0] ins, input logic [31:0] a,
                                           input logic [31:0] b);
        case ({ins[31:25], ins[14:12]})
            10'b0100000_000: return a - b;
            10'b0000000_111: return a & b;
            10'b0000000_110: return a | b;
            10'b0000000_100: return a ^ b;
            default:         return a + b;
        endcase
    endfunction

    // ALU stand-in: the result of an issue seen in cycle t appears in cycle t+L.
    always @(posedge clk) begin
        #1;
        bus.Result_in = res_sr[L-1];
    end

    always @(negedge clk) begin : monitor
        logic [31:0] ea, eb, ei, er;
        logic [36:0] ew;
        if (rst) begin
            exp_a_q.delete();
            exp_b_q.delete();
            exp_i_q.delete();
            exp_r_q.delete();
            exp_wb_q.delete();
            for (int i = 0; i < L; i++) res_sr[i] = '0;
        end else begin
            for (int i = L - 1; i > 0; i--) res_sr[i] = res_sr[i-1];
            res_sr[0] = '0;
            if (bus.issue_valid) begin
                checks++;
                if (exp_a_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected A=%h B=%h instr=%h, expected no issue",
                             bus.A_out, bus.B_out, bus.instr_out);
                end else begin
                    ea = exp_a_q.pop_front();
                    eb = exp_b_q.pop_front();
                    ei = exp_i_q.pop_front();
                    er = exp_r_q.pop_front();
                    res_sr[0] = er;
                    if ({bus.A_out, bus.B_out, bus.instr_out} !== {ea, eb, ei}) begin
                        errors++;
                        $display("FAIL issue_data A=%h B=%h instr=%h, expected A=%h B=%h instr=%h",
                                 bus.A_out, bus.B_out, bus.instr_out, ea, eb, ei);
                    end
                end
            end
            if (wb_valid) begin
                checks++;
                if (exp_wb_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected rd=%0d data=%h, expected no writeback", wb_rd, wb_data);
                end else begin
                    ew = exp_wb_q.pop_front();
                    if ({wb_rd, wb_data} !== ew) begin
                        errors++;
                        $display("FAIL wb_data rd=%0d data=%h, expected rd=%0d data=%h",
                                 wb_rd, wb_data, ew[36:32], ew[31:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] rd, input logic [31:0] data);
        ld_valid = 1'b1;
        ld_rd    = rd;
        ld_data  = data;
        tick();
        ld_valid = 1'b0;
        if (rd != 5'd0) m_reg[rd] = data;
    endtask

    // Presents one word, counts stalled cycles, returns at +1 of the issue cycle.
    task automatic send(input logic [31:0] ins, output int stalls);
        logic        lg;
        logic [31:0] a, b, r;
        int          guard;
        lg     = legal_of(ins);
        stalls = 0;
        guard  = 0;
        bus.instr_valid = 1'b1;
        bus.instr_in    = ins;
        #1;
        while (!bus.instr_ready && guard < 40) begin
            stalls++;
            guard++;
            @(posedge clk);
            #2;
        end
        if (!bus.instr_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout instr=%h ready=%b, expected ready within 40 cycles",
                     ins, bus.instr_ready);
            bus.instr_valid = 1'b0;
            bus.instr_in    = '0;
            tick();
            return;
        end
        if (lg) begin
            a = m_reg[ins[19:15]];
            b = m_reg[ins[24:20]];
            r = alu_of(ins, a, b);
            exp_a_q.push_back(a);
            exp_b_q.push_back(b);
            exp_i_q.push_back(ins);
            exp_r_q.push_back(r);
            if (ins[11:7] != 5'd0) begin
                exp_wb_q.push_back({ins[11:7], r});
                m_reg[ins[11:7]] = r;
            end
        end
        tick();
        bus.instr_valid = 1'b0;
        bus.instr_in    = '0;
        checks++;
        if (bus.issue_valid !== lg) begin
            errors++;
            $display("FAIL issue_valid_timing instr=%h got=%b, expected %b", ins, bus.issue_valid, lg);
        end
        checks++;
        if (illegal_pulse !== !lg) begin
            errors++;
            $display("FAIL illegal_pulse_timing instr=%h got=%b, expected %b", ins, illegal_pulse, !lg);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a_q.size() != 0 || exp_wb_q.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (exp_a_q.size() != 0 || exp_wb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending_issue=%0d pending_wb=%0d, expected 0 and 0",
                     exp_a_q.size(), exp_wb_q.size());
        end
    endtask

    task automatic dbg_expect(input logic [4:0] addr, input string name);
        dbg_addr = addr;
        #1;
        checks++;
        if (dbg_data !== m_reg[addr]) begin
            errors++;
            $display("FAIL %s x%0d=%h, expected %h", name, addr, dbg_data, m_reg[addr]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        #1;
        checks++;
        if ({bus.issue_valid, wb_valid, illegal_pulse, bus.instr_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags issue=%b wb=%b ill=%b ready=%b, expected all 0",
                     bus.issue_valid, wb_valid, illegal_pulse, bus.instr_ready);
        end
        checks++;
        if ({bus.A_out, bus.B_out, bus.instr_out} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data A=%h B=%h instr=%h, expected 0", bus.A_out, bus.B_out, bus.instr_out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b, expected 1", bus.instr_ready);
        end
        tick();
        dbg_expect(5'd1, "reset_reg");
        dbg_expect(5'd31, "reset_reg");
    endtask

    task automatic test_basic();
        int s;
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd3);
        send(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), s);
        repeat (L) tick();
        #1;
        checks++;
        if ({wb_valid, wb_rd} !== {1'b1, 5'd3}) begin
            errors++;
            $display("FAIL basic_wb_latency wb_valid=%b wb_rd=%0d, expected 1 and 3", wb_valid, wb_rd);
        end
        tick();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_wb_single got=%b, expected 0", wb_valid);
        end
        drain();
        dbg_expect(5'd3, "basic_x3");
    endtask

    task automatic test_raw();
        int s1, s2;
        preload(5'd3, 32'h55);
        send(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), s1);
        send(enc(7'h20, 5'd1, 5'd3, 3'b000, 5'd4), s2);
        checks++;
        if (s2 !== DEP_STALL) begin
            errors++;
            $display("FAIL raw_stall cycles=%0d, expected %0d", s2, DEP_STALL);
        end
        drain();
        dbg_expect(5'd4, "raw_x4");
    endtask

    task automatic test_stream();
        int s, total;
        logic [2:0] f3s [4];
        f3s[0] = 3'b000; f3s[1] = 3'b111; f3s[2] = 3'b110; f3s[3] = 3'b100;
        total = 0;
        preload(5'd5, 32'hF0F0F0F0);
        preload(5'd6, 32'h0FF00FF0);
        for (int i = 0; i < 4; i++) begin
            send(enc(7'h00, 5'd6, 5'd5, f3s[i], 5'(10 + i)), s);
            total += s;
        end
        checks++;
        if (total !== 0) begin
            errors++;
            $display("FAIL stream_stall cycles=%0d, expected 0", total);
        end
        drain();
        for (int i = 0; i < 4; i++) dbg_expect(5'(10 + i), "stream_reg");
    endtask

    task automatic test_illegal();
        int s;
        send(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), s);
        // ADDI x2,x3,0: rs1 names the in-flight rd, yet must not stall.
        send(32'h00018113, s);
        checks++;
        if (s !== 0) begin
            errors++;
            $display("FAIL illegal_stall cycles=%0d, expected 0", s);
        end
        checks++;
        if (bus.A_out !== m_reg[1]) begin
            errors++;
            $display("FAIL illegal_hold A=%h, expected %h", bus.A_out, m_reg[1]);
        end
        tick();
        checks++;
        if (illegal_pulse !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse_width got=%b, expected 0", illegal_pulse);
        end
        send(32'h00000013, s);
        send(enc(7'h20, 5'd2, 5'd1, 3'b111, 5'd9), s);
        drain();
    endtask

    task automatic test_x0();
        int s;
        preload(5'd0, 32'd99);
        preload(5'd7, 32'h77);
        send(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), s);
        send(enc(7'h00, 5'd0, 5'd0, 3'b000, 5'd7), s);
        checks++;
        if (s !== 0) begin
            errors++;
            $display("FAIL x0_stall cycles=%0d, expected 0", s);
        end
        drain();
        dbg_expect(5'd0, "x0_reg");
        dbg_expect(5'd7, "x0_x7");
    endtask

    task automatic test_preload_collision();
        int s;
        send(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd8), s);
        repeat (L) tick();
        ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 32'h1234;
        tick();
        ld_valid = 1'b0;
        dbg_expect(5'd8, "collide_same_rd");
        send(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd14), s);
        repeat (L) tick();
        preload(5'd9, 32'h77);
        dbg_expect(5'd9, "collide_ld_rd");
        dbg_expect(5'd14, "collide_wb_rd");
        drain();
    endtask

    task automatic test_reset_mid();
        int s;
        send(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), s);
        rst = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if ({bus.issue_valid, wb_valid, bus.instr_ready, bus.A_out, bus.B_out} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs issue=%b wb=%b ready=%b A=%h B=%h, expected 0",
                     bus.issue_valid, wb_valid, bus.instr_ready, bus.A_out, bus.B_out);
        end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        #1;
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready got=%b, expected 1", bus.instr_ready);
        end
        repeat (3) tick();
        dbg_expect(5'd3, "reset_mid_x3");
        dbg_expect(5'd1, "reset_mid_x1");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        for (int i = 0; i < L; i++) res_sr[i] = '0;
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr_in    = '0;
        bus.Result_in   = '0;
        ld_valid        = 1'b0;
        ld_rd           = '0;
        ld_data         = '0;
        dbg_addr        = '0;

        test_reset();
        test_basic();
        test_raw();
        test_stream();
        test_illegal();
        test_x0();
        test_preload_collision();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
